// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared state encoding and default frame width for the uart_tx frame path.
`default_nettype none

package uart_tx_arbiter_pkg;

  localparam int UART_FRAME_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_SEND   = 2'd2,
    ST_GAP    = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from the port after 'last'.
`default_nettype none

module rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [IDX_W-1:0] cand;

  // Explicit N-1 -> 0 wrap so N need not be a power of two.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = last;
    for (int k = 0; k < N; k++) begin
      cand = (cand == IDX_W'(N - 1)) ? '0 : cand + IDX_W'(1);
      if (!gnt_any && req[cand]) begin
        gnt_idx = cand;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, frame-at-a-time sharing of one uart_tx among NUM_PORTS AXIS sources.
`default_nettype none

module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int FRAME_WIDTH = UART_FRAME_WIDTH,
  parameter int GAP_CYCLES  = 0,
  localparam int IDX_W      = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS*FRAME_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  output logic [NUM_PORTS-1:0]             s_axis_tready,
  output logic [FRAME_WIDTH-1:0]           m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [IDX_W-1:0]                 m_axis_tid,
  output logic                             busy
);

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  arb_state_t       state;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] last_grant;
  logic [GAP_W-1:0] gap_cnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;

  rr_arbiter #(.N(NUM_PORTS)) u_rr (
    .req     (s_axis_tvalid),
    .last    (last_grant),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      grant         <= '0;
      last_grant    <= IDX_W'(NUM_PORTS - 1);
      gap_cnt       <= '0;
      s_axis_tready <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tid    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            grant         <= gnt_idx;
            s_axis_tready <= NUM_PORTS'(1) << gnt_idx;
            state         <= ST_ACCEPT;
          end
        end
        ST_ACCEPT: begin
          s_axis_tready <= '0;
          // A source that withdrew its valid forfeits the slot; its turn is not consumed.
          if (s_axis_tvalid[grant]) begin
            m_axis_tdata  <= s_axis_tdata[grant*FRAME_WIDTH +: FRAME_WIDTH];
            m_axis_tid    <= grant;
            m_axis_tvalid <= 1'b1;
            state         <= ST_SEND;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            last_grant    <= grant;
            gap_cnt       <= '0;
            state         <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
